// File: rtl/game_msg_tx.sv
// Multiplayer game message transmitter: turns ready/hit/game-over events into UART bytes.
// One byte per SEND cycle and at least a GAP_CYCLES idle window between bytes; waits in IDLE while tx_full.
module game_msg_tx #(
  parameter logic [7:0] CHAR_READY   = 8'h52,
  parameter logic [7:0] CHAR_HIT     = 8'h48,
  parameter logic [7:0] CHAR_OVER    = 8'h56,
  parameter int         GAP_CYCLES   = 16,
  parameter int         READY_PERIOD = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       multiplayer,
  input  logic       player_ready,
  input  logic       player_hit,
  input  logic       game_over,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       hit_overflow
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int HW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [HW-1:0]   hb_cnt_q, hb_cnt_d;
  logic [3:0]      hit_cnt_q, hit_cnt_d;
  logic            over_pend_q, over_pend_d;
  logic            ready_pend_q, ready_pend_d;
  logic            hit_ovf_q, hit_ovf_d;
  logic            hit_in_q, over_in_q, ready_in_q;
  logic            arm_q;
  logic            wr_uart_q, wr_uart_d;
  logic [7:0]      w_data_q, w_data_d;

  logic any_pend, launch, clear;
  logic hit_evt, over_evt, ready_evt, hb_tick;
  logic take_over, take_hit, take_ready;

  // arm_q masks the first cycle after reset so a level already high is not seen as an edge
  assign hit_evt   = arm_q & multiplayer & player_hit   & ~hit_in_q;
  assign over_evt  = arm_q & multiplayer & game_over    & ~over_in_q;
  assign ready_evt = arm_q & multiplayer & player_ready & ~ready_in_q;
  assign hb_tick   = multiplayer & player_ready & (hb_cnt_q == HW'(READY_PERIOD - 1));
  assign any_pend  = over_pend_q | ready_pend_q | (hit_cnt_q != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      hb_cnt_q     <= '0;
      hit_cnt_q    <= 4'd0;
      over_pend_q  <= 1'b0;
      ready_pend_q <= 1'b0;
      hit_ovf_q    <= 1'b0;
      hit_in_q     <= 1'b0;
      over_in_q    <= 1'b0;
      ready_in_q   <= 1'b0;
      arm_q        <= 1'b0;
      wr_uart_q    <= 1'b0;
      w_data_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      hb_cnt_q     <= hb_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      over_pend_q  <= over_pend_d;
      ready_pend_q <= ready_pend_d;
      hit_ovf_q    <= hit_ovf_d;
      hit_in_q     <= player_hit;
      over_in_q    <= game_over;
      ready_in_q   <= player_ready;
      arm_q        <= 1'b1;
      wr_uart_q    <= wr_uart_d;
      w_data_q     <= w_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (multiplayer && !tx_full && any_pend) state_d = SEND;
      SEND: state_d = (w_data_q == CHAR_OVER) ? DONE : GAP;
      GAP:  if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
      DONE: if (!multiplayer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    launch     = (state_q == IDLE) && (state_d == SEND);
    clear      = (state_q == DONE) ||
                 (!multiplayer && ((state_q == IDLE) || (state_q == GAP)));
    take_over  = 1'b0;
    take_hit   = 1'b0;
    take_ready = 1'b0;
    wr_uart_d  = launch;
    w_data_d   = w_data_q;
    // the byte is chosen and its pending state consumed on entry to SEND
    if (launch) begin
      if (over_pend_q) begin
        take_over = 1'b1;
        w_data_d  = CHAR_OVER;
      end else if (hit_cnt_q != 4'd0) begin
        take_hit = 1'b1;
        w_data_d = CHAR_HIT;
      end else begin
        take_ready = 1'b1;
        w_data_d   = CHAR_READY;
      end
    end

    over_pend_d  = (over_pend_q & ~take_over) | over_evt;
    ready_pend_d = (ready_pend_q & ~take_ready) | ready_evt | hb_tick;
    hit_cnt_d    = hit_cnt_q;
    hit_ovf_d    = hit_ovf_q;
    case ({hit_evt, take_hit})
      2'b10: begin
        if (hit_cnt_q == 4'd15) hit_ovf_d = 1'b1;
        else                    hit_cnt_d = hit_cnt_q + 4'd1;
      end
      2'b01:   hit_cnt_d = hit_cnt_q - 4'd1;
      default: hit_cnt_d = hit_cnt_q;
    endcase

    hb_cnt_d  = (multiplayer && player_ready && !hb_tick) ? hb_cnt_q + HW'(1) : '0;
    gap_cnt_d = (state_q == GAP) ? gap_cnt_q + GW'(1) : '0;

    if (clear) begin
      over_pend_d  = 1'b0;
      ready_pend_d = 1'b0;
      hit_cnt_d    = 4'd0;
      hb_cnt_d     = '0;
    end
  end

  assign wr_uart      = wr_uart_q;
  assign w_data       = w_data_q;
  assign busy         = any_pend || (state_q == SEND) || (state_q == GAP);
  assign hit_overflow = hit_ovf_q;

endmodule
